// File: rtl/fp_mult_seq.sv
// Sequencer around a fixed-latency FP multiplier: issues requests, tracks tags
// through the pipe, and returns results in order from a credit-guarded FIFO.
module fp_mult_seq #(
  parameter int          TAG_W    = 4,
  parameter int          DEPTH    = 4,
  parameter int          LAT      = 2,
  parameter logic [7:0]  ERR_MASK = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_rnd,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  output logic [2:0]       mult_rnd,
  input  logic [31:0]      mult_z,
  input  logic [7:0]       mult_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_z,
  output logic [7:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + 8 + TAG_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic             ready_q, ready_d;
  logic [31:0]      ma_q, ma_d;
  logic [31:0]      mb_q, mb_d;
  logic [2:0]       mr_q, mr_d;
  logic [LAT:0]     vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [0:LAT];
  logic [TAG_W-1:0] tag_d [0:LAT];
  logic [EW-1:0]    mem_q [0:DEPTH-1];
  logic [EW-1:0]    mem_d [0:DEPTH-1];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    out_q, out_d;
  logic [15:0]      err_q, err_d;

  logic accept;
  logic push;
  logic pop;

  always_comb begin
    accept  = req_valid & ready_q;
    push    = vld_q[LAT];
    pop     = (cnt_q != '0) & rsp_ready;
    ma_d    = ma_q;
    mb_d    = mb_q;
    mr_d    = mr_q;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    err_d   = err_q;
    if (accept) begin
      ma_d = req_a;
      mb_d = req_b;
      mr_d = req_rnd;
    end
    // Marker stage LAT is the one whose result is on mult_z this cycle.
    vld_d    = {vld_q[LAT-1:0], accept};
    tag_d[0] = req_tag;
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (push) begin
      mem_d[wp_q] = {mult_z, mult_status, tag_q[LAT]};
      wp_d        = wp_q + PW'(1);
      if (|(mult_status & ERR_MASK) && err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    out_d   = out_q + CW'(accept) - CW'(pop);
    ready_d = out_d < DEPTH_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      mr_q    <= '0;
      vld_q   <= '0;
      tag_q   <= '{default: '0};
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      ready_q <= ready_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      mr_q    <= mr_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst) push |-> cnt_q < DEPTH_C
  );

  assign req_ready = ready_q;
  assign mult_a    = ma_q;
  assign mult_b    = mb_q;
  assign mult_rnd  = mr_q;
  assign rsp_valid = cnt_q != '0;
  assign {rsp_z, rsp_status, rsp_tag} = mem_q[rp_q];
  assign busy      = out_q != '0;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: 2-stage multiplier stand-in, queue scoreboard and
// a negedge monitor that checks every response handshake.
module tb_fp_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_rnd;
  logic [3:0]  req_tag;
  logic [31:0] mult_a, mult_b;
  logic [2:0]  mult_rnd;
  logic [31:0] mult_z;
  logic [7:0]  mult_status;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic [7:0]  rsp_status;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  logic [43:0] sb [$];
  logic [39:0] p1;

  always #5 clk = ~clk;

  fp_mult_seq #(
    .TAG_W(4), .DEPTH(4), .LAT(2), .ERR_MASK(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd), .req_tag(req_tag),
    .mult_a(mult_a), .mult_b(mult_b), .mult_rnd(mult_rnd),
    .mult_z(mult_z), .mult_status(mult_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_status(rsp_status), .rsp_tag(rsp_tag),
    .busy(busy), .err_cnt(err_cnt)
  );

  // Truncating multiplier, normals/zero/inf only; inf*0 gives qNaN + invalid.
  function automatic logic [39:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [47:0] p;
    logic [9:0]  e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00))
      return {32'h7FC00000, 8'h01};
    if (ea == 8'hFF || eb == 8'hFF)
      return {s, 8'hFF, 23'd0, 8'h00};
    if (ea == 8'h00 || eb == 8'h00)
      return {s, 31'd0, 8'h00};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, ea} + {2'b0, eb} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24], 8'h00};
    return {s, e[7:0], p[45:23], 8'h00};
  endfunction

  always @(posedge clk) begin
    p1 <= fmul(mult_a, mult_b);
    {mult_z, mult_status} <= p1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("stale_rsp", {20'd0, rsp_z, rsp_status, rsp_tag}, 64'd0);
      end else begin
        chk("rsp", {20'd0, rsp_z, rsp_status, rsp_tag}, {20'd0, sb.pop_front()});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] ez,
                       input logic [7:0] es);
    int k;
    req_a = a; req_b = b; req_rnd = 3'd0; req_tag = tag;
    req_valid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (req_ready) break;
      k++;
    end
    if (k == 50) chk("issue_timeout", 64'd0, 64'd1);
    else sb.push_back({ez, es, tag});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic lat_chk(input string nm);
    int n;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk(nm, 64'(n), 64'd4);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_a [5] = '{32'h3F800000, 32'h40000000, 32'h3FC00000,
                            32'hBF800000, 32'h40400000};
  logic [31:0] bp_b [5] = '{32'h3F800000, 32'h40000000, 32'h40000000,
                            32'h3F000000, 32'h40400000};
  logic [31:0] bp_z [5] = '{32'h3F800000, 32'h40800000, 32'h40400000,
                            32'hBF000000, 32'h41100000};

  initial begin
    int idx;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_rnd = '0; req_tag = '0; rsp_ready = 1'b1;
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_mult_a", 64'(mult_a), 64'd0);
    @(negedge clk); rst = 1'b0;

    issue(32'h3F800000, 32'h40000000, 4'd5, 32'h40000000, 8'h00);
    lat_chk("lat_single");
    drain();
    chk("err_single", 64'(err_cnt), 64'd0);

    issue(32'h3FC00000, 32'h40000000, 4'd0, 32'h40400000, 8'h00);
    issue(32'h40400000, 32'h40400000, 4'd1, 32'h41100000, 8'h00);
    issue(32'hBF800000, 32'h3F000000, 4'd2, 32'hBF000000, 8'h00);
    issue(32'h40000000, 32'h40000000, 4'd3, 32'h40800000, 8'h00);
    drain();

    rsp_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1; req_a = bp_a[0]; req_b = bp_b[0]; req_tag = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({bp_z[idx], 8'h00, 4'(8 + idx)});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 5) begin
        req_a = bp_a[idx]; req_b = bp_b[idx]; req_tag = 4'(8 + idx);
      end
    end
    chk("bp_accepts", 64'(idx), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_back", 64'(req_ready), 64'd1);
    if (req_ready) begin
      sb.push_back({bp_z[4], 8'h00, 4'd12});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    issue(32'h7F800000, 32'h00000000, 4'd6, 32'h7FC00000, 8'h01);
    drain();
    chk("err_inf0", 64'(err_cnt), 64'd1);
    issue(32'h3F800000, 32'h3F800000, 4'd4, 32'h3F800000, 8'h00);
    drain();
    chk("err_hold", 64'(err_cnt), 64'd1);

    rsp_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 4'd1, 32'h3F800000, 8'h00);
    issue(32'h40000000, 32'h40000000, 4'd2, 32'h40800000, 8'h00);
    issue(32'h40400000, 32'h40400000, 4'd3, 32'h41100000, 8'h00);
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mult_a", 64'(mult_a), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    sb.delete();
    rsp_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    issue(32'h3F800000, 32'h40000000, 4'd7, 32'h40000000, 8'h00);
    lat_chk("lat_after_rst");
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
